// File: rtl/rr_grant_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared state encoding, sizes and index helper for the
//               round-robin grant arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // OR-reduction of indices is exact only for one-hot or all-zero input.
    function automatic logic [ID_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_arbiter_if
// Description : Request/grant bundle between requesters and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_grant_arbiter_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             idle;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  idle,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output idle,
        output timeout
    );

endinterface
`default_nettype wire

// File: rtl/rr_grant_arbiter_prio_enc8.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc8
// Description : 8-bit priority encoder, highest set index wins; one-hot,
//               binary index and 'none' outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc8
    import arb_pkg::*;
(
    input  wire logic [N_REQ-1:0] i_req,
    output logic      [N_REQ-1:0] o_onehot,
    output logic      [ID_W-1:0]  o_idx,
    output logic                  o_none
);

    logic [N_REQ-1:0] w_oh;

    // Ascending scan: each later hit overwrites, leaving the highest index.
    always_comb begin
        w_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_req[i]) begin
                w_oh    = '0;
                w_oh[i] = 1'b1;
            end
        end
    end

    assign o_onehot = w_oh;
    assign o_idx    = onehot_to_idx(w_oh);
    assign o_none   = ~|i_req;

endmodule
`default_nettype wire

// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_arbiter
// Description : 8-way round-robin arbiter with descending rotation, grant
//               hold until release/done, and a hold-timeout forced release.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rr_grant_arbiter_if.slave  bus
);

    localparam int              HC_W        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] c_HOLD_LAST = HC_W'(MAX_HOLD - 1);

    state_t           r_state;
    logic [N-1:0]     r_gnt;
    logic [ID_W-1:0]  r_gnt_id;
    logic [ID_W-1:0]  r_last;
    logic [HC_W-1:0]  r_hold;
    logic             r_timeout;

    state_t           w_state_nxt;
    logic [N-1:0]     w_gnt_nxt;
    logic [ID_W-1:0]  w_gnt_id_nxt;
    logic [ID_W-1:0]  w_last_nxt;
    logic [HC_W-1:0]  w_hold_nxt;
    logic             w_timeout_nxt;

    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_req_msk;
    logic [N-1:0]     w_msk_oh;
    logic [N-1:0]     w_all_oh;
    logic [ID_W-1:0]  w_msk_id;
    logic [ID_W-1:0]  w_all_id;
    logic             w_msk_none;
    logic             w_all_none;
    logic [N-1:0]     w_sel_oh;
    logic [ID_W-1:0]  w_sel_id;

    logic             w_rel_drop;
    logic             w_rel_done;
    logic             w_rel_hold;
    logic             w_release;

    // Requesters strictly below the previous owner; empty when last is 0.
    assign w_mask    = (N'(1) << r_last) - N'(1);
    assign w_req_msk = bus.req & w_mask;

    prio_enc8 u_enc_msk (
        .i_req    (w_req_msk),
        .o_onehot (w_msk_oh),
        .o_idx    (w_msk_id),
        .o_none   (w_msk_none)
    );

    prio_enc8 u_enc_all (
        .i_req    (bus.req),
        .o_onehot (w_all_oh),
        .o_idx    (w_all_id),
        .o_none   (w_all_none)
    );

    assign w_sel_oh = w_msk_none ? w_all_oh : w_msk_oh;
    assign w_sel_id = w_msk_none ? w_all_id : w_msk_id;

    assign w_rel_drop = ~bus.req[r_gnt_id];
    assign w_rel_done = bus.done;
    assign w_rel_hold = (r_hold == c_HOLD_LAST);
    assign w_release  = w_rel_drop | w_rel_done | w_rel_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_last    <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_last    <= w_last_nxt;
            r_hold    <= w_hold_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_last_nxt    = r_last;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_all_none) begin
                    w_state_nxt  = ST_GRANT;
                    w_gnt_nxt    = w_sel_oh;
                    w_gnt_id_nxt = w_sel_id;
                    w_hold_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt   = ST_IDLE;
                    w_gnt_nxt     = '0;
                    w_last_nxt    = r_gnt_id;
                    // Timeout flags only a purely forced release.
                    w_timeout_nxt = w_rel_hold & ~w_rel_drop & ~w_rel_done;
                end else begin
                    w_hold_nxt = r_hold + HC_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_id  = r_gnt_id;
    assign bus.idle    = (r_state == ST_IDLE);
    assign bus.timeout = r_timeout;

endmodule
`default_nettype wire
